// File: rtl/lifo_pkg.sv
// Shared types and sizing for the LIFO unloader: FSM states, read latency of the
// upstream LIFO and depth of the skid buffer that absorbs it.
package lifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } unloader_state_t;

  localparam int LIFO_RD_LATENCY    = 1;
  localparam int UNLOADER_BUF_DEPTH = 3;
  localparam int OCC_W              = $clog2(UNLOADER_BUF_DEPTH + 1);

endpackage

// File: rtl/lifo_unloader_if.sv
// LIFO read side plus output stream of the unloader; master = the unloader itself.
// Suffixes give direction as seen from the master.
interface lifo_unloader_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);

  logic              lifo_rdreq_o;
  logic [DWIDTH-1:0] lifo_q_i;
  logic              lifo_empty_i;
  logic [AWIDTH:0]   lifo_usedw_i;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              last_o;
  logic              ready_i;

  modport master (
    output lifo_rdreq_o, data_o, valid_o, last_o,
    input  lifo_q_i, lifo_empty_i, lifo_usedw_i, ready_i
  );

  modport slave (
    input  lifo_rdreq_o, data_o, valid_o, last_o,
    output lifo_q_i, lifo_empty_i, lifo_usedw_i, ready_i
  );

endinterface

// File: rtl/lifo_unloader_buf.sv
// 3-entry shift FIFO of {last, data}; head and occupancy come straight from registers.
// Write lands at the first free slot after any same-cycle shift, so order is preserved.
module lifo_unloader_buf
  import lifo_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              wr_i,
  input  logic [DWIDTH-1:0] wdat_i,
  input  logic              wlast_i,
  input  logic              rd_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic              valid_o,
  output logic [DWIDTH-1:0] dat_o,
  output logic              last_o
);

  logic [DWIDTH:0]    mem_q [UNLOADER_BUF_DEPTH];
  logic [OCC_W-1:0]   occ_q, occ_d, wr_idx;

  always_comb begin
    occ_d = occ_q;
    if (wr_i && !rd_i) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (rd_i && !wr_i) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  assign wr_idx = rd_i ? (occ_q - OCC_W'(1)) : occ_q;

  // Slots at or above occ are kept zero, so an empty buffer presents zero data.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < UNLOADER_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      if (rd_i) begin
        for (int i = 0; i < UNLOADER_BUF_DEPTH - 1; i++) begin
          mem_q[i] <= mem_q[i+1];
        end
        mem_q[UNLOADER_BUF_DEPTH-1] <= '0;
      end
      for (int i = 0; i < UNLOADER_BUF_DEPTH; i++) begin
        if (wr_i && (wr_idx == OCC_W'(i))) begin
          mem_q[i] <= {wlast_i, wdat_i};
        end
      end
      occ_q <= occ_d;
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != '0);
  assign dat_o   = mem_q[0][DWIDTH-1:0];
  assign last_o  = mem_q[0][DWIDTH];

endmodule

// File: rtl/lifo_unloader.sv
// Drains a snapshot-sized burst from the LIFO onto a valid/ready stream; first valid 2 cycles
// after start, then 1 word/cycle. Reads are credit-limited so sink stalls never overflow the buffer.
module lifo_unloader
  import lifo_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  lifo_unloader_if.master bus
);

  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  unloader_state_t            state_q;
  logic [AWIDTH:0]            issue_cnt_q;
  logic [LIFO_RD_LATENCY-1:0] rd_hist_q;
  logic [LIFO_RD_LATENCY-1:0] last_hist_q;
  logic                       done_q;
  logic                       rdreq, issue_last, pop;
  logic                       buf_valid, buf_last;
  logic [OCC_W-1:0]           occ;

  assign issue_last = (issue_cnt_q == CNT_ONE);

  // Reads still in the LIFO pipeline hold a buffer slot just like captured words.
  assign rdreq = (state_q == DRAIN) && (issue_cnt_q != '0) && !bus.lifo_empty_i &&
                 (($countones(rd_hist_q) + int'(occ)) < UNLOADER_BUF_DEPTH);

  assign pop = buf_valid && bus.ready_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rd_hist_q   <= '0;
      last_hist_q <= '0;
      done_q      <= 1'b0;
    end else begin
      rd_hist_q   <= LIFO_RD_LATENCY'({rd_hist_q, rdreq});
      last_hist_q <= LIFO_RD_LATENCY'({last_hist_q, rdreq && issue_last});
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && !bus.lifo_empty_i) begin
            state_q     <= DRAIN;
            issue_cnt_q <= bus.lifo_usedw_i;
          end
        end
        DRAIN: begin
          if (rdreq) begin
            issue_cnt_q <= issue_cnt_q - CNT_ONE;
            if (issue_last) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (pop && buf_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  lifo_unloader_buf #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .wr_i    (rd_hist_q[LIFO_RD_LATENCY-1]),
    .wdat_i  (bus.lifo_q_i),
    .wlast_i (last_hist_q[LIFO_RD_LATENCY-1]),
    .rd_i    (pop),
    .occ_o   (occ),
    .valid_o (buf_valid),
    .dat_o   (bus.data_o),
    .last_o  (buf_last)
  );

  assign bus.lifo_rdreq_o = rdreq;
  assign bus.valid_o      = buf_valid;
  assign bus.last_o       = buf_last;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;

endmodule

// File: tb/tb_lifo_unloader.sv
// Directed bench for lifo_unloader with a behavioural 256-deep LIFO (1-cycle read latency)
// driving its read side; table of bursts plus hand sequences for stall, mid-burst writes and reset.
module tb_lifo_unloader;

  typedef struct {
    int          n;
    bit          rnd;
    logic [15:0] base;
    logic [15:0] exp_first;
    logic [15:0] exp_final;
  } vec_t;

  logic        clk = 1'b0;
  logic        arstn, start, ready, busy, done;
  logic        wr;
  logic [15:0] wdat;

  logic [15:0] lmem [256];
  int          lcnt = 0;
  logic [15:0] lq   = '0;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] hs_dat [$];
  bit          hs_last [$];
  int          hs_cyc [$];
  int          rd_cnt = 0, done_cnt = 0, rd_empty_err = 0, stable_err = 0;
  bit          stall_pend = 1'b0;
  logic [15:0] stall_dat = '0;
  bit          stall_last = 1'b0;

  vec_t        vecs [5];

  lifo_unloader_if #(.DWIDTH(16), .AWIDTH(8)) bus ();

  lifo_unloader #(.DWIDTH(16), .AWIDTH(8)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .bus     (bus)
  );

  assign bus.lifo_q_i     = lq;
  assign bus.lifo_empty_i = (lcnt == 0);
  assign bus.lifo_usedw_i = 9'(lcnt);
  assign bus.ready_i      = ready;

  always #5 clk = ~clk;

  // LIFO model: a push in the same cycle as a pop replaces the popped slot.
  always @(posedge clk) begin
    if (bus.lifo_rdreq_o && lcnt != 0) begin
      lq <= lmem[lcnt-1];
      if (wr) lmem[lcnt-1] <= wdat;
      else    lcnt <= lcnt - 1;
    end else if (wr && lcnt < 256) begin
      lmem[lcnt] <= wdat;
      lcnt <= lcnt + 1;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (arstn) begin
      if (bus.valid_o && bus.ready_i) begin
        hs_dat.push_back(bus.data_o);
        hs_last.push_back(bus.last_o);
        hs_cyc.push_back(cyc);
      end
      if (bus.lifo_rdreq_o) rd_cnt++;
      if (bus.lifo_rdreq_o && bus.lifo_empty_i) rd_empty_err++;
      if (done) done_cnt++;
      if (stall_pend && (!bus.valid_o || bus.data_o !== stall_dat || bus.last_o !== stall_last))
        stable_err++;
      stall_pend = bus.valid_o && !bus.ready_i;
      stall_dat  = bus.data_o;
      stall_last = bus.last_o;
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input logic [15:0] exp[$]);
    int bad = 0;
    int lasts = 0;
    chk({nm, "_count"}, 32'(hs_dat.size()), 32'(exp.size()));
    for (int i = 0; i < hs_dat.size(); i++) begin
      if (i >= exp.size() || hs_dat[i] !== exp[i]) bad++;
      if (hs_last[i]) lasts++;
    end
    chk({nm, "_order_errs"}, 32'(bad), 32'd0);
    chk({nm, "_last_cnt"}, 32'(lasts), 32'd1);
    chk({nm, "_last_on_final"}, 32'(hs_last.size() > 0 && hs_last[hs_last.size()-1]), 32'd1);
  endtask

  task automatic clear_hs();
    hs_dat.delete();
    hs_last.delete();
    hs_cyc.delete();
  endtask

  task automatic lifo_push(input logic [15:0] d);
    wr = 1'b1;
    wdat = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse_start(output int e0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input bit rnd, output int done_at);
    done_at = -1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    chk("done_seen", 32'(done_at >= 0), 32'd1);
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int          e0, done_at, hs_n;
    string       p;
    logic [15:0] exp_q [$];
    p = $sformatf("v%0d", idx);
    for (int i = 0; i < v.n; i++) lifo_push(v.base + 16'(i));
    clear_hs();
    ready = 1'b1;
    pulse_start(e0);
    @(negedge clk);
    chk({p, "_valid_k1"}, 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    chk({p, "_valid_k2"}, 32'(bus.valid_o), 32'd1);
    chk({p, "_data_k2"}, 32'(bus.data_o), 32'(v.exp_first));
    wait_done(v.rnd, done_at);
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.base + 16'(v.n - 1 - i));
    chk_seq(p, exp_q);
    hs_n = hs_dat.size();
    if (hs_n > 0) begin
      chk({p, "_first"}, 32'(hs_dat[0]), 32'(v.exp_first));
      chk({p, "_final"}, 32'(hs_dat[hs_n-1]), 32'(v.exp_final));
      chk({p, "_done_after_last"}, 32'(done_at), 32'(hs_cyc[hs_n-1]));
      if (!v.rnd) begin
        // last handshake is in cycle N+1 after the start edge, sampled at the edge closing it
        chk({p, "_last_edge"}, 32'(hs_cyc[hs_n-1] - e0), 32'(v.n + 2));
        chk({p, "_back_to_back"}, 32'(hs_cyc[hs_n-1] - hs_cyc[0]), 32'(v.n - 1));
      end
    end
    chk({p, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({p, "_lifo_empty"}, 32'(lcnt), 32'd0);
    @(negedge clk);
    chk({p, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          e0, done_at, rd0, d0;
    logic [15:0] e [$];

    vecs[0] = '{5,   1'b0, 16'h00A0, 16'h00A4, 16'h00A0};
    vecs[1] = '{256, 1'b0, 16'h1000, 16'h10FF, 16'h1000};
    vecs[2] = '{10,  1'b1, 16'h2000, 16'h2009, 16'h2000};
    vecs[3] = '{1,   1'b0, 16'h3000, 16'h3000, 16'h3000};
    vecs[4] = '{3,   1'b1, 16'h4400, 16'h4402, 16'h4400};

    arstn = 1'b0; start = 1'b0; ready = 1'b0; wr = 1'b0; wdat = '0;
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_rdreq", 32'(bus.lifo_rdreq_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_last",  32'(bus.last_o), 32'd0);
    chk("rst_data",  32'(bus.data_o), 32'd0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) run_vector(v, vecs[v]);

    // start on an empty LIFO does nothing
    rd0 = rd_cnt;
    d0 = done_cnt;
    pulse_start(e0);
    repeat (4) @(negedge clk);
    chk("empty_busy",  32'(busy), 32'd0);
    chk("empty_rdreq", 32'(rd_cnt - rd0), 32'd0);
    chk("empty_done",  32'(done_cnt - d0), 32'd0);

    // stalled burst; new words arrive and a second start is pulsed mid-burst
    for (int i = 0; i < 6; i++) lifo_push(16'h0040 + 16'(i));
    ready = 1'b0;
    clear_hs();
    pulse_start(e0);
    repeat (6) @(negedge clk);
    chk("stall_valid",  32'(bus.valid_o), 32'd1);
    chk("stall_data",   32'(bus.data_o), 32'h45);
    chk("stall_popped", 32'(lcnt), 32'd3);
    for (int i = 0; i < 4; i++) lifo_push(16'h0048 + 16'(i));
    pulse_start(e0);
    chk("midstart_busy", 32'(busy), 32'd1);
    wait_done(1'b0, done_at);
    e = '{16'h45, 16'h44, 16'h43, 16'h4B, 16'h4A, 16'h49};
    chk_seq("midstart", e);
    chk("midstart_left", 32'(lcnt), 32'd4);
    clear_hs();
    pulse_start(e0);
    wait_done(1'b0, done_at);
    e = '{16'h48, 16'h42, 16'h41, 16'h40};
    chk_seq("leftover", e);

    // X,Y pushed while draining 8 words
    for (int i = 0; i < 8; i++) lifo_push(16'h0050 + 16'(i));
    ready = 1'b1;
    clear_hs();
    pulse_start(e0);
    repeat (2) @(negedge clk);
    wr = 1'b1; wdat = 16'hCAFE;
    @(negedge clk);
    wdat = 16'hBEEF;
    @(negedge clk);
    wr = 1'b0;
    wait_done(1'b0, done_at);
    e = '{16'h57, 16'h56, 16'h55, 16'hCAFE, 16'hBEEF, 16'h54, 16'h53, 16'h52};
    chk_seq("wr_during", e);
    chk("wr_during_usedw", 32'(bus.lifo_usedw_i), 32'd2);
    clear_hs();
    pulse_start(e0);
    wait_done(1'b0, done_at);
    e = '{16'h51, 16'h50};
    chk_seq("wr_rest", e);

    // reset once 3 of 6 words have left the LIFO
    for (int i = 0; i < 6; i++) lifo_push(16'h0060 + 16'(i));
    ready = 1'b1;
    clear_hs();
    pulse_start(e0);
    for (int i = 0; i < 20 && lcnt != 3; i++) @(negedge clk);
    chk("pre_rst_popped", 32'(lcnt), 32'd3);
    arstn = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_done",  32'(done), 32'd0);
    chk("mid_rst_rdreq", 32'(bus.lifo_rdreq_o), 32'd0);
    chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    chk("mid_rst_last",  32'(bus.last_o), 32'd0);
    chk("mid_rst_data",  32'(bus.data_o), 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_lifo", 32'(lcnt), 32'd3);
    clear_hs();
    pulse_start(e0);
    wait_done(1'b0, done_at);
    e = '{16'h62, 16'h61, 16'h60};
    chk_seq("post_rst", e);
    chk("post_rst_empty", 32'(lcnt), 32'd0);

    chk("rdreq_while_empty", 32'(rd_empty_err), 32'd0);
    chk("stall_stability", 32'(stable_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_unloader.md
# lifo_unloader

Drains a burst of words from the `lifo` block and presents them on a valid/ready stream with an end-of-burst marker. It sits directly downstream of `lifo`: it drives `rdreq_i` and consumes `q_o`, `empty_o` and `usedw_o`. A 3-entry output buffer with credit-based read issue absorbs the LIFO's 1-cycle read latency and sink back-pressure. No word is lost or duplicated, and throughput is 1 word/cycle while `ready_i` is high.

## Interface
- `DWIDTH`, 16: data width; must match `lifo`.
- `AWIDTH`, 8: LIFO address width; `usedw` is `AWIDTH+1` bits.
- `clk_i` in 1: clock; single clock domain.
- `arstn_i` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: 1-cycle pulse that requests draining of the current LIFO contents.
- `busy_o` out 1: high from burst accept until the last word is accepted by the sink.
- `done_o` out 1: 1-cycle pulse, the cycle after the last word is accepted.
- `lifo_rdreq_o` out 1: to `lifo.rdreq_i`.
- `lifo_q_i` in DWIDTH: from `lifo.q_o`.
- `lifo_empty_i` in 1: from `lifo.empty_o`.
- `lifo_usedw_i` in AWIDTH+1: from `lifo.usedw_o`.
- `data_o` out DWIDTH: stream data.
- `valid_o` out 1: stream valid.
- `last_o` out 1: marks the final word of the burst; qualified by `valid_o`.
- `ready_i` in 1: sink ready.

## Operation
- Reset (`arstn_i`=0): state IDLE, all counters 0, buffer empty; `busy_o`, `done_o`, `lifo_rdreq_o`, `valid_o` and `last_o` are 0; `data_o` is 0. Reset mid-burst discards the burst and any buffered words. The LIFO contents are not touched.
- FSM states:
  - IDLE → DRAIN when `start_i`=1 and `lifo_empty_i`=0. On that edge, latch `issue_cnt` = `lifo_usedw_i` (range 1..2**AWIDTH, AWIDTH+1 bits).
  - `start_i` while `lifo_empty_i`=1 is ignored: no `done_o`.
  - `start_i` while not IDLE is ignored.
  - DRAIN → FLUSH when the final read is issued (`issue_cnt` 1→0).
  - FLUSH → IDLE when the word with `last_o`=1 is accepted (`valid_o`&&`ready_i`); `done_o` pulses the next cycle.
- Read issue: `lifo_rdreq_o` = DRAIN && `issue_cnt`≠0 && !`lifo_empty_i` && (`inflight` + `occ`) < 3.
  - `inflight` is 1 if `lifo_rdreq_o` was high last cycle.
  - `occ` is the registered buffer occupancy (0..3).
  - `lifo_rdreq_o` is never asserted while `lifo_empty_i`=1. If the LIFO empties early, for example because another agent popped it, the block stalls in DRAIN until data appears.
  - There is no combinational path from `ready_i` to `lifo_rdreq_o`.
- Capture: the cycle after a read issue, `{lifo_q_i, last}` is written into the buffer. `last` is 1 for the read issued with `issue_cnt`=1.
- Burst length is fixed at the start snapshot. Writes into the LIFO during a burst are allowed. Because the LIFO is last-in-first-out, these newer words are popped first, and the burst still ends after exactly the snapshot count.
- Output: `data_o`, `last_o` and `valid_o` = buffer head / non-empty. Once `valid_o`=1, it stays 1 and `data_o`/`last_o` stay stable until accepted.
- Simultaneous buffer write and read in the same cycle: `occ` is unchanged, ordering is preserved.

## Timing
- Edge E0 samples `start_i`=1. `lifo_rdreq_o` is high in the cycle after E0. The LIFO pops at E1, the buffer captures at E2, and `valid_o` is high after E2. Start-to-first-valid latency is 2 cycles.
- Steady state with `ready_i`=1: 1 word/cycle. An N-word burst ends with the `last_o` handshake N+1 cycles after E0.
- With `ready_i`=0, at most 3 words are buffered. Issue resumes the cycle after a handshake frees a credit.
- `busy_o`=1 in DRAIN and FLUSH. `done_o` coincides with the first IDLE cycle.

## Structure
- Package `lifo_pkg`:
  - state enum `unloader_state_t` {IDLE, DRAIN, FLUSH};
  - `LIFO_RD_LATENCY`=1;
  - `UNLOADER_BUF_DEPTH`=3.
- Sub-module `lifo_unloader_buf`: 3-entry synchronous FIFO of {DWIDTH data, last}, with registered `occ` and head outputs and async active-low reset. The top level holds the FSM, `issue_cnt` and the credit logic.

## Test plan
- Write 5 words A..E into `lifo`, pulse `start_i`, `ready_i`=1 → `data_o` = E,D,C,B,A on consecutive cycles; `last_o` only on A; first valid 2 cycles after the start edge; `done_o` one cycle after A; `lifo.empty_o`=1.
- Full LIFO (256 words), `ready_i`=1 → 256 handshakes in 256 consecutive cycles, order is the reverse of the writes, exactly one `last_o`.
- 10 words, `ready_i` random 50% → order and count are correct; `valid_o`/`data_o` are stable while stalled; `occ` ≤3; never `lifo_rdreq_o` with `empty_o`=1.
- `start_i` on an empty LIFO, then `start_i` pulsed mid-burst → no activity and no `done_o` for the first; the second is ignored and the burst count is unchanged.
- 8-word burst, while the LIFO keeps receiving writes of new words X,Y during the drain → exactly 8 words out, including X,Y (popped first), `last_o` on the 8th; 2 old words remain in the LIFO (`usedw_o`=2).
- `arstn_i` low after 3 of 6 words → all outputs 0 immediately; after release, `busy_o`=0; a new `start_i` drains the remaining 3 words with `last_o` on the third.
